restoring_divu: RTL and testbench

- Sequential unsigned restoring divider that uses the same Start_sig/Done_sig handshake as the team's Booth multiplier (BOOTHU).
- It computes Dividend / Divisor one quotient bit per clock and returns Quotient and Remainder.
- It sits alongside the multiplier in the arithmetic unit, so a shared controller can drive either block with identical sequencing.

---
 rtl/divu_pkg.sv | 10 +
 rtl/divu_step.sv | 18 +
 rtl/restoring_divu.sv | 95 +++++++++
 tb/tb_restoring_divu.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/divu_pkg.sv
// divu_pkg: state encoding and default width shared by the divider and its users.
package divu_pkg;
    localparam int DIVU_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CALC     = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } divu_state_t;
endpackage

// File: rtl/divu_step.sv
// divu_step: one restoring-division iteration (shift in the dividend MSB, trial subtract, restore on borrow).
module divu_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r,
    output logic             o_q_bit
);
    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_t;
    assign w_sh    = {i_r, i_q_msb};
    assign w_t     = w_sh - {1'b0, i_d};
    assign o_q_bit = ~w_t[WIDTH];
    // A rejected trial means the shifted value was below D, so it fits in WIDTH bits
    assign o_r     = o_q_bit ? w_t[WIDTH-1:0] : w_sh[WIDTH-1:0];
endmodule

// File: rtl/restoring_divu.sv
// restoring_divu: sequential unsigned restoring divider, one quotient bit per clock,
// with the Start_sig/Done_sig level handshake shared with the Booth multiplier.
module restoring_divu
    import divu_pkg::*;
#(
    parameter int WIDTH = DIVU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start_sig,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Done_sig,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Div_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    divu_state_t      r_state;
    divu_state_t      w_next;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;
    logic [WIDTH-1:0] w_r_next;
    logic             w_q_bit;
    logic             w_last;

    divu_step #(.WIDTH(WIDTH)) u_step (
        .i_r     (r_r),
        .i_q_msb (r_q[WIDTH-1]),
        .i_d     (r_d),
        .o_r     (w_r_next),
        .o_q_bit (w_q_bit)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = Start_sig ? CALC : IDLE;
            CALC:     w_next = w_last ? DONE : CALC;
            DONE:     w_next = Start_sig ? WAIT_LOW : IDLE;
            WAIT_LOW: w_next = Start_sig ? WAIT_LOW : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r    <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (r_state == IDLE && Start_sig) begin
                r_r   <= '0;
                r_q   <= Dividend;
                r_d   <= Divisor;
                r_dz  <= (Divisor == '0);
                r_cnt <= '0;
            end
            if (r_state == CALC) begin
                r_r   <= w_r_next;
                r_q   <= {r_q[WIDTH-2:0], w_q_bit};
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == DONE) begin
                r_quot <= r_q;
                r_rem  <= r_r;
            end
        end
    end

    assign Done_sig  = r_done;
    assign Quotient  = r_quot;
    assign Remainder = r_rem;
    assign Div_zero  = r_dz;
endmodule

// File: tb/tb_restoring_divu.sv
// tb_restoring_divu: table-driven, hand-sequenced and random checks of restoring_divu
// against a plain-arithmetic division model.
module tb_restoring_divu;
    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         Start_sig;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Done_sig;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Div_zero;

    int n_cmp = 0;
    int n_err = 0;

    restoring_divu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start_sig (Start_sig),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Done_sig  (Done_sig),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Div_zero  (Div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
    endfunction

    function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : W'(int'(a) % int'(b));
    endfunction

    // Issue one request from IDLE, check latency and results, then release the handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edz, input int hold, input bit scr,
                          input string tag);
        int n;
        int extra;
        @(negedge clk);
        Dividend  = a;
        Divisor   = b;
        Start_sig = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (scr && n == 2) begin
                Dividend = 8'd1;
                Divisor  = 8'd1;
            end
        end while (!Done_sig && n < 30);
        check({tag, "_latency"}, n, LAT);
        check({tag, "_quot"}, int'(Quotient), int'(eq));
        check({tag, "_rem"}, int'(Remainder), int'(er));
        check({tag, "_dz"}, int'(Div_zero), int'(edz));
        extra = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (Done_sig) extra++;
        end
        if (hold > 0) check({tag, "_no_redone"}, extra, 0);
        Start_sig = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, int'(Done_sig), 0);
        check({tag, "_quot_held"}, int'(Quotient), int'(eq));
    endtask

    vec_t tbl[8];

    initial begin
        int n;
        logic [W-1:0] a;
        logic [W-1:0] b;
        tbl[0] = '{8'd64,  8'd4,   8'd16,  8'd0, 1'b0};
        tbl[1] = '{8'd200, 8'd7,   8'd28,  8'd4, 1'b0};
        tbl[2] = '{8'd3,   8'd10,  8'd0,   8'd3, 1'b0};
        tbl[3] = '{8'd255, 8'd255, 8'd1,   8'd0, 1'b0};
        tbl[4] = '{8'd5,   8'd0,   8'd255, 8'd5, 1'b1};
        tbl[5] = '{8'd100, 8'd9,   8'd11,  8'd1, 1'b0};
        tbl[6] = '{8'd0,   8'd5,   8'd0,   8'd0, 1'b0};
        tbl[7] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0};

        rst_n     = 1'b0;
        Start_sig = 1'b0;
        Dividend  = '0;
        Divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", int'(Done_sig), 0);
        check("rst_quot", int'(Quotient), 0);
        check("rst_rem", int'(Remainder), 0);
        check("rst_dz", int'(Div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, 0, 1'b0, $sformatf("tbl%0d", i));

        run_op(8'd64, 8'd4, 8'd16, 8'd0, 1'b0, 20, 1'b0, "hold");
        run_op(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 0, 1'b0, "after_hold");
        run_op(8'd64, 8'd4, 8'd16, 8'd0, 1'b0, 0, 1'b1, "scramble");

        // Abort mid-calculation with an asynchronous reset
        run_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 0, 1'b0, "pre_rst");
        @(negedge clk);
        Dividend  = 8'd64;
        Divisor   = 8'd4;
        Start_sig = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        Start_sig = 1'b0;
        #1;
        check("abort_done", int'(Done_sig), 0);
        check("abort_quot", int'(Quotient), 0);
        check("abort_rem", int'(Remainder), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (Done_sig) n++;
        end
        check("abort_no_done", n, 0);
        run_op(8'd64, 8'd4, 8'd16, 8'd0, 1'b0, 0, 1'b0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom_range(0, 255));
            b = (i % 10 == 0) ? '0 : W'($urandom_range(0, 255));
            run_op(a, b, model_q(a, b), model_r(a, b), (b == 0), 0, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
